// File: rtl/counter_mon_pkg.sv
// rtl/counter_mon_pkg.sv - shared types and default sizing for the counter monitor
package counter_mon_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_STAT_W    = 8;
  localparam int DEF_ERR_LIMIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TR_LEGAL   = 2'd0,
    TR_WRAP    = 2'd1,
    TR_RESTART = 2'd2,
    TR_ERROR   = 2'd3
  } trans_e;

endpackage

// File: rtl/counter_monitor_if.sv
// rtl/counter_monitor_if.sv - monitored-count inputs, controls and status outputs of the monitor
interface counter_monitor_if import counter_mon_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAT_W = DEF_STAT_W
);
  logic [WIDTH-1:0]  count;
  logic              arm;
  logic              clr;
  logic              locked;
  logic              wrap_pulse;
  logic              restart_pulse;
  logic              err_pulse;
  logic              err_flag;
  logic [STAT_W-1:0] wrap_cnt;
  logic [STAT_W-1:0] restart_cnt;
  logic [STAT_W-1:0] err_cnt;
  logic [WIDTH-1:0]  last_bad;
  logic [WIDTH-1:0]  last_exp;

  modport master (
    output count, arm, clr,
    input  locked, wrap_pulse, restart_pulse, err_pulse, err_flag,
    input  wrap_cnt, restart_cnt, err_cnt, last_bad, last_exp
  );

  modport slave (
    input  count, arm, clr,
    output locked, wrap_pulse, restart_pulse, err_pulse, err_flag,
    output wrap_cnt, restart_cnt, err_cnt, last_bad, last_exp
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);
  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
endmodule

// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - checks that an upstream free-running counter steps by one,
// classifying each sample as legal, wrap, restart or error and keeping statistics.
module counter_monitor import counter_mon_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int STAT_W    = DEF_STAT_W,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT
) (
  input logic               clk,
  input logic               rst,
  counter_monitor_if.slave  bus
);
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W:0]   ERR_LIM  = (STAT_W+1)'(ERR_LIMIT);

  function automatic trans_e classify(input logic [WIDTH-1:0] prev, input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] nxt;
    nxt = prev + WIDTH'(1);
    if (cur == nxt)       return (prev == CNT_MAX) ? TR_WRAP : TR_LEGAL;
    else if (cur == '0)   return TR_RESTART;
    else                  return TR_ERROR;
  endfunction

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  last_bad_q, last_bad_d;
  logic [WIDTH-1:0]  last_exp_q, last_exp_d;
  logic              locked_q, err_flag_q;
  logic              wrap_pulse_q, restart_pulse_q, err_pulse_q;
  logic              wrap_ev, restart_ev, err_ev;
  logic [STAT_W-1:0] wrap_cnt, restart_cnt, err_cnt;
  logic [STAT_W:0]   err_inc;
  trans_e            trans;

  // ERROR entry is judged on the count including the error being recorded now
  assign err_inc = (err_cnt == STAT_MAX) ? {1'b0, err_cnt} : {1'b0, err_cnt} + (STAT_W+1)'(1);
  assign trans   = classify(prev_q, bus.count);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    last_bad_d = last_bad_q;
    last_exp_d = last_exp_q;
    wrap_ev    = 1'b0;
    restart_ev = 1'b0;
    err_ev     = 1'b0;
    if (bus.clr) begin
      state_d    = ST_IDLE;
      prev_d     = '0;
      last_bad_d = '0;
      last_exp_d = '0;
    end else if (!bus.arm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_SYNC;
        ST_SYNC: begin
          prev_d  = bus.count;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          case (trans)
            TR_LEGAL: prev_d = bus.count;
            TR_WRAP: begin
              prev_d  = bus.count;
              wrap_ev = 1'b1;
            end
            TR_RESTART: begin
              prev_d     = '0;
              restart_ev = 1'b1;
            end
            default: begin
              err_ev     = 1'b1;
              last_bad_d = bus.count;
              last_exp_d = prev_q + WIDTH'(1);
              state_d    = (err_inc >= ERR_LIM) ? ST_ERROR : ST_SYNC;
            end
          endcase
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      prev_q          <= '0;
      last_bad_q      <= '0;
      last_exp_q      <= '0;
      locked_q        <= 1'b0;
      err_flag_q      <= 1'b0;
      wrap_pulse_q    <= 1'b0;
      restart_pulse_q <= 1'b0;
      err_pulse_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      last_bad_q      <= last_bad_d;
      last_exp_q      <= last_exp_d;
      locked_q        <= (state_d == ST_TRACK);
      err_flag_q      <= (state_d == ST_ERROR);
      wrap_pulse_q    <= wrap_ev;
      restart_pulse_q <= restart_ev;
      err_pulse_q     <= err_ev;
    end
  end

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk(clk), .rst(rst), .inc(wrap_ev), .clr(bus.clr), .value(wrap_cnt)
  );
  sat_counter #(.W(STAT_W)) u_restart_cnt (
    .clk(clk), .rst(rst), .inc(restart_ev), .clr(bus.clr), .value(restart_cnt)
  );
  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .inc(err_ev), .clr(bus.clr), .value(err_cnt)
  );

  assign bus.locked        = locked_q;
  assign bus.wrap_pulse    = wrap_pulse_q;
  assign bus.restart_pulse = restart_pulse_q;
  assign bus.err_pulse     = err_pulse_q;
  assign bus.err_flag      = err_flag_q;
  assign bus.wrap_cnt      = wrap_cnt;
  assign bus.restart_cnt   = restart_cnt;
  assign bus.err_cnt       = err_cnt;
  assign bus.last_bad      = last_bad_q;
  assign bus.last_exp      = last_exp_q;
endmodule

// File: tb/tb_counter_monitor.sv
// tb/tb_counter_monitor.sv - directed bench for counter_monitor (default and STAT_W=2 instances)
module tb_counter_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       arm = 1'b0;
  logic       clr = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         nw, w0, w1, nerr;

  counter_monitor_if #(.WIDTH(4), .STAT_W(8)) bus ();
  counter_monitor_if #(.WIDTH(4), .STAT_W(2)) bus2 ();

  assign bus.count  = cnt;
  assign bus.arm    = arm;
  assign bus.clr    = clr;
  assign bus2.count = cnt;
  assign bus2.arm   = arm;
  assign bus2.clr   = clr;

  counter_monitor #(.WIDTH(4), .STAT_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  counter_monitor #(.WIDTH(4), .STAT_W(2), .ERR_LIMIT(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] c);
    cnt = c;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    check("rst_locked",   32'(bus.locked), 0);
    check("rst_wrap_cnt", 32'(bus.wrap_cnt), 0);
    check("rst_err_flag", 32'(bus.err_flag), 0);
    check("rst_last_exp", 32'(bus.last_exp), 0);

    // clean upstream count for 40 samples
    rst = 1'b1;
    arm = 1'b1;
    nw = 0; w0 = 0; w1 = 0;
    for (int k = 1; k <= 40; k++) begin
      step(4'(k - 1));
      if (bus.wrap_pulse) begin
        if (nw == 0) w0 = k;
        else if (nw == 1) w1 = k;
        nw++;
      end
    end
    check("clean_locked",      32'(bus.locked), 1);
    check("clean_wrap_cnt",    32'(bus.wrap_cnt), 2);
    check("clean_err_cnt",     32'(bus.err_cnt), 0);
    check("clean_restart_cnt", 32'(bus.restart_cnt), 0);
    check("clean_wrap_pulses", 32'(nw), 2);
    check("clean_first_wrap",  32'(w0), 17);
    check("clean_wrap_gap",    32'(w1 - w0), 16);

    // 7 -> 9 jump
    step(4'd9);
    check("jump_err_pulse", 32'(bus.err_pulse), 1);
    check("jump_last_bad",  32'(bus.last_bad), 9);
    check("jump_last_exp",  32'(bus.last_exp), 8);
    check("jump_err_cnt",   32'(bus.err_cnt), 1);
    check("jump_unlocked",  32'(bus.locked), 0);
    step(4'd3);
    check("jump_relocked",  32'(bus.locked), 1);
    check("jump_pulse_end", 32'(bus.err_pulse), 0);

    // 5 -> 0 upstream restart
    step(4'd4);
    step(4'd5);
    step(4'd0);
    check("rs_pulse",       32'(bus.restart_pulse), 1);
    check("rs_cnt",         32'(bus.restart_cnt), 1);
    check("rs_locked",      32'(bus.locked), 1);
    check("rs_err_cnt",     32'(bus.err_cnt), 1);
    check("rs_no_wrap",     32'(bus.wrap_pulse), 0);
    step(4'd1);
    check("rs_pulse_end",   32'(bus.restart_pulse), 0);

    // clr coinciding with an illegal sample
    clr = 1'b1;
    step(4'd7);
    check("clr_no_err_pulse", 32'(bus.err_pulse), 0);
    check("clr_err_cnt",      32'(bus.err_cnt), 0);
    check("clr_restart_cnt",  32'(bus.restart_cnt), 0);
    check("clr_wrap_cnt",     32'(bus.wrap_cnt), 0);
    check("clr_last_bad",     32'(bus.last_bad), 0);
    check("clr_locked",       32'(bus.locked), 0);
    clr = 1'b0;
    step(4'd8);
    check("clr_sync_unlocked", 32'(bus.locked), 0);
    step(4'd9);
    check("clr_track_locked",  32'(bus.locked), 1);
    step(4'd10);

    // three separate errors reach ERR_LIMIT
    step(4'd3);
    check("e1_pulse",  32'(bus.err_pulse), 1);
    check("e1_cnt",    32'(bus.err_cnt), 1);
    step(4'd4);
    step(4'd5);
    step(4'd12);
    check("e2_cnt",    32'(bus.err_cnt), 2);
    check("e2_flag",   32'(bus.err_flag), 0);
    step(4'd13);
    step(4'd13);
    check("e3_pulse",    32'(bus.err_pulse), 1);
    check("e3_cnt",      32'(bus.err_cnt), 3);
    check("e3_flag",     32'(bus.err_flag), 1);
    check("e3_locked",   32'(bus.locked), 0);
    check("e3_last_bad", 32'(bus.last_bad), 13);
    check("e3_last_exp", 32'(bus.last_exp), 14);
    step(4'd14);
    check("err_hold_pulse", 32'(bus.err_pulse), 0);
    check("err_hold_flag",  32'(bus.err_flag), 1);

    // disarm from ERROR, then clear and re-arm
    arm = 1'b0;
    step(4'd15);
    check("disarm_flag",     32'(bus.err_flag), 0);
    check("disarm_err_cnt",  32'(bus.err_cnt), 3);
    check("disarm_last_bad", 32'(bus.last_bad), 13);
    arm = 1'b1;
    clr = 1'b1;
    step(4'd0);
    check("clr2_err_cnt",  32'(bus.err_cnt), 0);
    check("clr2_last_exp", 32'(bus.last_exp), 0);
    clr = 1'b0;
    step(4'd1);
    check("clr2_sync_unlocked", 32'(bus.locked), 0);
    step(4'd2);
    check("clr2_track_locked",  32'(bus.locked), 1);

    // build some state, then reset while an error pulse is in flight
    step(4'd3);
    step(4'd0);
    check("pre_rst_restart", 32'(bus.restart_cnt), 1);
    for (int c = 1; c <= 14; c++) step(4'(c));
    step(4'd7);
    check("pre_rst_err_pulse", 32'(bus.err_pulse), 1);
    check("pre_rst_last_exp",  32'(bus.last_exp), 15);
    cnt = 4'd14;
    #2;
    rst = 1'b0;
    #1;
    check("arst_err_pulse",   32'(bus.err_pulse), 0);
    check("arst_locked",      32'(bus.locked), 0);
    check("arst_restart_cnt", 32'(bus.restart_cnt), 0);
    check("arst_err_cnt",     32'(bus.err_cnt), 0);
    check("arst_last_bad",    32'(bus.last_bad), 0);
    check("arst_last_exp",    32'(bus.last_exp), 0);
    tick();
    tick();
    rst = 1'b1;

    // resync after reset, then five wraps
    nerr = 0;
    step(4'd15);
    if (bus.err_pulse) nerr++;
    step(4'd0);
    if (bus.err_pulse) nerr++;
    check("resync_locked", 32'(bus.locked), 1);
    for (int c = 1; c <= 80; c++) begin
      step(4'(c));
      if (bus.err_pulse) nerr++;
    end
    check("resync_no_err",   32'(nerr), 0);
    check("wrap5_cnt_w8",    32'(bus.wrap_cnt), 5);
    check("wrap5_cnt_w2_sat", 32'(bus2.wrap_cnt), 3);
    check("wrap5_locked_w2", 32'(bus2.locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter WIDTH, default 4: width of the monitored count.
REQ-002 Parameter STAT_W, default 8: width of each statistics counter.
REQ-003 Parameter ERR_LIMIT, default 3: error count at which the monitor enters ERROR.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 count  input  WIDTH  output of the upstream free-running counter, sampled each rising edge.
REQ-007 arm  input  1  high enables monitoring; low returns the monitor to IDLE.
REQ-008 clr  input  1  synchronous clear of the statistics, the error flag and the state.
REQ-009 locked  output  1  high while in TRACK.
REQ-010 wrap_pulse  output  1  one-cycle pulse on a legal max-to-0 transition.
REQ-011 restart_pulse  output  1  one-cycle pulse on a non-wrap jump to 0 (upstream reset seen).
REQ-012 err_pulse  output  1  one-cycle pulse on an illegal transition.
REQ-013 err_flag  output  1  sticky; high while in ERROR.
REQ-014 wrap_cnt, restart_cnt, err_cnt  output  STAT_W each  saturating event counters.
REQ-015 last_bad, last_exp  output  WIDTH each  observed and expected values at the most recent error.

Function
REQ-016 States: IDLE, SYNC, TRACK, ERROR; all outputs are registered.
REQ-017 IDLE: arm=1 -> SYNC; otherwise stay; statistics hold.
REQ-018 SYNC: prev <= count; next state TRACK; no event pulses.
REQ-019 TRACK legal step: count == prev+1 mod 2^WIDTH. Action: prev <= count; if prev == 2^WIDTH-1, wrap_pulse=1 and wrap_cnt increments.
REQ-020 TRACK restart: count == 0 and prev != 2^WIDTH-1. Action: restart_pulse=1, restart_cnt increments, prev <= 0, stay in TRACK, no error.
REQ-021 TRACK any other value (including count == prev, a stall):
- err_pulse=1, err_cnt increments, last_bad <= count, last_exp <= prev+1.
- If the incremented err_cnt >= ERR_LIMIT -> ERROR; else -> SYNC.
REQ-022 ERROR: err_flag=1, locked=0; stays until clr=1 or arm=0.
REQ-023 Pulses are visible in the cycle after the rising edge at which the triggering count is sampled (1-cycle latency).
REQ-024 Each pulse is high for exactly one cycle per event; back-to-back events give consecutive pulses.
REQ-025 Statistics counters saturate at 2^STAT_W-1 and never wrap.
REQ-026 arm=0 in any state -> IDLE next cycle; statistics, last_bad and last_exp hold; err_flag clears.
REQ-027 Priority clr > arm=0 > state logic:
- clr=1 -> IDLE, all statistics, last_bad, last_exp and err_flag set to 0, no pulses.
- This holds even when an event coincides with clr.
REQ-028 locked is asserted in the cycle after the SYNC->TRACK edge and deasserts in the cycle after leaving TRACK.

Reset
REQ-029 rst low asynchronously forces IDLE.
REQ-030 Reset values: all outputs 0; prev = 0.
REQ-031 Release of rst is synchronous to clk; the first evaluation occurs on the first rising edge with rst high.
REQ-032 rst assertion mid-TRACK discards all in-flight pulses.

Structure
REQ-033 Shared package counter_mon_pkg holds the state enum type and the default WIDTH/STAT_W/ERR_LIMIT constants.
REQ-034 Sub-module sat_counter (parameter W; inputs inc, clr; output value) is instantiated three times, for wrap_cnt, restart_cnt and err_cnt.
REQ-035 The transition classification (legal / wrap / restart / error) is a single combinational function of prev and count.

Verification
REQ-036 Monitor a correct upstream counter with arm=1 for 40 cycles -> locked=1, wrap_cnt=2, err_cnt=0, restart_cnt=0, 2 wrap_pulses 16 cycles apart.
REQ-037 Force count 5->0 mid-TRACK -> restart_pulse once, restart_cnt=1, err_cnt=0, locked stays 1.
REQ-038 Force count 7->9 -> err_pulse, last_bad=9, last_exp=8, err_cnt=1, SYNC then TRACK (locked low exactly 1 cycle).
REQ-039 Inject 3 separate illegal jumps -> err_cnt=3, err_flag=1, locked=0; then clr=1 for one cycle -> all counters 0, IDLE, and TRACK resumes 2 cycles later with arm=1.
REQ-040 Set STAT_W=2 and run 5 wraps -> wrap_cnt saturates at 3.
REQ-041 Assert rst low mid-TRACK with count=14 -> all outputs 0 immediately; after release the monitor resyncs with no err_pulse.
